// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue stage.
package div_pkg;

    localparam int XLEN = 32;
    localparam int REG_TAG_WIDTH = 5;

    localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        DRAIN  = 2'b11
    } div_state_e;

    function automatic logic opIsSigned(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic opWantsRem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Single-cycle resolution of divide-by-zero, signed overflow and result-cache hits.
module div_special_case
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic                  cache_valid_i,
    input  logic                  cache_signed_i,
    input  logic [DATA_WIDTH-1:0] cache_rs1_i,
    input  logic [DATA_WIDTH-1:0] cache_rs2_i,
    input  logic [DATA_WIDTH-1:0] cache_quotient_i,
    input  logic [DATA_WIDTH-1:0] cache_remainder_i,
    output logic                  fast_hit_o,
    output logic [DATA_WIDTH-1:0] fast_quotient_o,
    output logic [DATA_WIDTH-1:0] fast_remainder_o
);

    logic divByZero;
    logic overflow;
    logic cacheHit;

    assign divByZero = (rs2_i == '0);
    assign overflow  = signed_i && (rs1_i == INT_MIN) && (rs2_i == '1);
    assign cacheHit  = cache_valid_i
                    && (cache_signed_i == signed_i)
                    && (cache_rs1_i == rs1_i)
                    && (cache_rs2_i == rs2_i);

    assign fast_hit_o = divByZero || overflow || cacheHit;

    // Divide-by-zero outranks overflow, which outranks the cache.
    always_comb begin
        fast_quotient_o  = '0;
        fast_remainder_o = '0;
        if (divByZero) begin
            fast_quotient_o  = DIV0_QUOTIENT;
            fast_remainder_o = rs1_i;
        end else if (overflow) begin
            fast_quotient_o  = INT_MIN;
            fast_remainder_o = '0;
        end else if (cacheHit) begin
            fast_quotient_o  = cache_quotient_i;
            fast_remainder_o = cache_remainder_i;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Issue/sequencing stage in front of the multicycle divider, with a one-entry result cache.
module div_ctrl
    import div_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int REG_ADDR_WIDTH = REG_TAG_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [1:0]                in_op_i,
    input  logic [DATA_WIDTH-1:0]     in_rs1_i,
    input  logic [DATA_WIDTH-1:0]     in_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_i,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_o,
    output logic [DATA_WIDTH-1:0]     out_result_o,
    output logic                      div_start_o,
    output logic [DATA_WIDTH-1:0]     div_dividend_o,
    output logic [DATA_WIDTH-1:0]     div_divisor_o,
    output logic                      div_signed_o,
    input  logic [DATA_WIDTH-1:0]     div_quotient_i,
    input  logic [DATA_WIDTH-1:0]     div_remainder_i,
    input  logic                      div_ready_i
);

    div_state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0]     dividend_q, dividend_d;
    logic [DATA_WIDTH-1:0]     divisor_q, divisor_d;
    logic                      signed_q, signed_d;
    logic                      wantRem_q, wantRem_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      outValid_q, outValid_d;
    logic [REG_ADDR_WIDTH-1:0] outRd_q, outRd_d;
    logic [DATA_WIDTH-1:0]     outResult_q, outResult_d;
    logic                      cacheValid_q, cacheValid_d;
    logic                      cacheSigned_q, cacheSigned_d;
    logic [DATA_WIDTH-1:0]     cacheRs1_q, cacheRs1_d;
    logic [DATA_WIDTH-1:0]     cacheRs2_q, cacheRs2_d;
    logic [DATA_WIDTH-1:0]     cacheQuo_q, cacheQuo_d;
    logic [DATA_WIDTH-1:0]     cacheRem_q, cacheRem_d;

    logic                      accept;
    logic                      inSigned;
    logic                      inWantRem;
    logic                      fastHit;
    logic [DATA_WIDTH-1:0]     fastQuotient;
    logic [DATA_WIDTH-1:0]     fastRemainder;

    assign in_ready_o = (state_q == IDLE) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign inSigned   = opIsSigned(in_op_i);
    assign inWantRem  = opWantsRem(in_op_i);

    div_special_case #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_special (
        .signed_i         (inSigned),
        .rs1_i            (in_rs1_i),
        .rs2_i            (in_rs2_i),
        .cache_valid_i    (cacheValid_q),
        .cache_signed_i   (cacheSigned_q),
        .cache_rs1_i      (cacheRs1_q),
        .cache_rs2_i      (cacheRs2_q),
        .cache_quotient_i (cacheQuo_q),
        .cache_remainder_i(cacheRem_q),
        .fast_hit_o       (fastHit),
        .fast_quotient_o  (fastQuotient),
        .fast_remainder_o (fastRemainder)
    );

    // A start with flush in the same cycle must never reach the divider.
    assign div_start_o    = (state_q == LAUNCH) && !flush_i;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_signed_o   = signed_q;
    assign out_valid_o    = outValid_q;
    assign out_rd_o       = outRd_q;
    assign out_result_o   = outResult_q;

    always_comb begin
        state_d       = state_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        signed_d      = signed_q;
        wantRem_d     = wantRem_q;
        rd_d          = rd_q;
        outValid_d    = 1'b0;
        outRd_d       = outRd_q;
        outResult_d   = outResult_q;
        cacheValid_d  = cacheValid_q;
        cacheSigned_d = cacheSigned_q;
        cacheRs1_d    = cacheRs1_q;
        cacheRs2_d    = cacheRs2_q;
        cacheQuo_d    = cacheQuo_q;
        cacheRem_d    = cacheRem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fastHit) begin
                        outValid_d  = 1'b1;
                        outRd_d     = in_rd_i;
                        outResult_d = inWantRem ? fastRemainder : fastQuotient;
                    end else begin
                        dividend_d = in_rs1_i;
                        divisor_d  = in_rs2_i;
                        signed_d   = inSigned;
                        wantRem_d  = inWantRem;
                        rd_d       = in_rd_i;
                        state_d    = LAUNCH;
                    end
                end
            end
            // The divider may still be chewing on an abandoned op; keep retrying the start.
            LAUNCH: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = div_ready_i ? IDLE : DRAIN;
                end else if (div_ready_i) begin
                    state_d       = IDLE;
                    outValid_d    = 1'b1;
                    outRd_d       = rd_q;
                    outResult_d   = wantRem_q ? div_remainder_i : div_quotient_i;
                    cacheValid_d  = 1'b1;
                    cacheSigned_d = signed_q;
                    cacheRs1_d    = dividend_q;
                    cacheRs2_d    = divisor_q;
                    cacheQuo_d    = div_quotient_i;
                    cacheRem_d    = div_remainder_i;
                end
            end
            DRAIN: begin
                if (div_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            dividend_q    <= '0;
            divisor_q     <= '0;
            signed_q      <= 1'b0;
            wantRem_q     <= 1'b0;
            rd_q          <= '0;
            outValid_q    <= 1'b0;
            outRd_q       <= '0;
            outResult_q   <= '0;
            cacheValid_q  <= 1'b0;
            cacheSigned_q <= 1'b0;
            cacheRs1_q    <= '0;
            cacheRs2_q    <= '0;
            cacheQuo_q    <= '0;
            cacheRem_q    <= '0;
        end else begin
            state_q       <= state_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            signed_q      <= signed_d;
            wantRem_q     <= wantRem_d;
            rd_q          <= rd_d;
            outValid_q    <= outValid_d;
            outRd_q       <= outRd_d;
            outResult_q   <= outResult_d;
            cacheValid_q  <= cacheValid_d;
            cacheSigned_q <= cacheSigned_d;
            cacheRs1_q    <= cacheRs1_d;
            cacheRs2_q    <= cacheRs2_d;
            cacheQuo_q    <= cacheQuo_d;
            cacheRem_q    <= cacheRem_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural 32-iteration divider beside it.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_signed;
    logic [31:0] div_quotient = '0;
    logic [31:0] div_remainder = '0;
    logic        div_ready = 1'b1;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        int          cycle;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   startCount = 0;
    int   holdCount  = 0;

    div_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_op_i        (in_op),
        .in_rs1_i       (in_rs1),
        .in_rs2_i       (in_rs2),
        .in_rd_i        (in_rd),
        .flush_i        (flush),
        .out_valid_o    (out_valid),
        .out_rd_o       (out_rd),
        .out_result_o   (out_result),
        .div_start_o    (div_start),
        .div_dividend_o (div_dividend),
        .div_divisor_o  (div_divisor),
        .div_signed_o   (div_signed),
        .div_quotient_i (div_quotient),
        .div_remainder_i(div_remainder),
        .div_ready_i    (div_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: ignores reset, drops ready on launch, ready again 34 cycles later.
    logic [31:0] dvA, dvB;
    logic        dvS;
    int          dvCount = 0;

    function automatic logic [63:0] divModel(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1; r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return {q, r};
    endfunction

    always @(posedge clk) begin
        if (div_ready && div_start) begin
            dvA        <= div_dividend;
            dvB        <= div_divisor;
            dvS        <= div_signed;
            div_ready  <= 1'b0;
            dvCount    <= 33;
            startCount <= startCount + 1;
        end else if (!div_ready) begin
            if (dvCount == 1) begin
                div_ready                     <= 1'b1;
                {div_quotient, div_remainder} <= divModel(dvA, dvB, dvS);
            end
            dvCount <= dvCount - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && div_start === 1'b1 && div_ready === 1'b0) holdCount++;
        if (!rst && out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_out_valid: got rd %0d result 0x%08h, expected no result", out_rd, out_result);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("rd[%0d]", e.rd), {27'b0, out_rd}, {27'b0, e.rd});
                checkOutput($sformatf("result[%0d]", e.rd), out_result, e.result);
                if (e.cycle >= 0) checkOutput($sformatf("latency[%0d]", e.rd), cyc, e.cycle);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] res, input int lat, input bit push);
        int waited = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout[%0d]: got in_ready 0, expected 1", rd);
            in_valid = 1'b0;
            return;
        end
        if (push) expQ.push_back('{rd: rd, result: res, cycle: (lat >= 0) ? cyc + lat : -1});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        in_op = DIV; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_div_start", {31'b0, div_start}, 32'd0);
        checkOutput("reset_out_result", out_result, 32'd0);
        checkOutput("reset_dividend", div_dividend, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Slow DIVU, then REMU on the same operands offered on the result cycle.
        s0 = startCount;
        applyStimulus(DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 36, 1);
        applyStimulus(REMU, 32'd100, 32'd7, 5'd2, 32'd2, 1, 1);
        waitDrain();
        checkOutput("launches_divu_remu", startCount - s0, 32'd1);

        // Overflow and divide-by-zero resolve without the divider.
        s0 = startCount;
        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 1, 1);
        applyStimulus(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 1, 1);
        applyStimulus(DIVU, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, 1, 1);
        applyStimulus(REM, 32'hFFFF_FFF9, 32'd0, 5'd6, 32'hFFFF_FFF9, 1, 1);
        waitDrain();
        checkOutput("launches_special", startCount - s0, 32'd0);

        // Signed pair shares one run; the unsigned variant must miss.
        s0 = startCount;
        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 36, 1);
        applyStimulus(REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 1, 1);
        applyStimulus(DIVU, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h7FFF_FFFC, 36, 1);
        waitDrain();
        checkOutput("launches_signed", startCount - s0, 32'd2);

        // Flush while waiting: no result, no cache fill, next op runs fully.
        applyStimulus(DIV, 32'd1000, 32'd10, 5'd10, 32'd0, -1, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        applyStimulus(DIV, 32'd1000, 32'd10, 5'd11, 32'd100, 36, 1);
        waitDrain();

        // Reset in WAIT; the abandoned run forces the next op to hold in LAUNCH.
        applyStimulus(DIV, 32'd50, 32'd5, 5'd12, 32'd0, -1, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("wait_reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("wait_reset_out_rd", {27'b0, out_rd}, 32'd0);
        checkOutput("wait_reset_out_result", out_result, 32'd0);
        checkOutput("wait_reset_div_start", {31'b0, div_start}, 32'd0);
        checkOutput("wait_reset_divisor", div_divisor, 32'd0);
        checkOutput("wait_reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        holdCount = 0;
        applyStimulus(DIV, 32'd9, 32'd3, 5'd13, 32'd3, 64, 1);
        waitDrain();
        checkOutput("launch_hold_cycles", holdCount, 32'd28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
